// File: rtl/pattern_gen_core_if.sv
// Pattern SRAM read port.
//   mem_rd_en  : read strobe, driven by the playback core
//   mem_addr   : read address, driven by the playback core
//   mem_rdata  : read data, valid exactly one cycle after mem_rd_en
// master = playback core, slave = SRAM.
interface pattern_gen_core_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_rd_en, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/pattern_gen_core.sv
// Pattern playback engine. Streams bytes from the pattern SRAM starting at
// address 0, slices each byte LSB-first into 1/2/4/8-bit samples and drives
// one sample per timestep onto gpio_out, optionally looping at end_address.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   enable          : level-sensitive run request
//   repeat_enable   : wrap to address 0 after end_address
//   end_address     : last byte played (inclusive)
//   num_gpio_sel    : bits per sample 00:1 01:2 10:4 11:8
//   timestep_sel    : sample period = 2**timestep_sel cycles
//   mem             : SRAM read port (master side)
//   gpio_out        : current sample, unused upper bits 0
//   busy, done      : playback in progress / non-repeat run finished
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for enable; settings latched on exit
// FILL  | first read issued, waiting for byte 0 to come back
// PLAY  | shifter holds a byte, samples are being driven
// DONE  | non-repeat run finished; held until enable falls
module pattern_gen_core #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8,
    parameter int TS_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 repeat_enable,
    input  logic [ADDR_W-1:0]    end_address,
    input  logic [1:0]           num_gpio_sel,
    input  logic [TS_W-1:0]      timestep_sel,
    pattern_gen_core_if.master   mem,
    output logic [7:0]           gpio_out,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_PLAY, ST_DONE} state_t;

    state_t state_q, state_d;

    logic              rep_q, rep_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [1:0]        gsel_q, gsel_d;
    logic [TS_W-1:0]   ts_q, ts_d;

    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_last_q, rd_last_d;
    logic              fetch_done_q, fetch_done_d;
    logic              rdv_q, rdv_d;
    logic              rdv_last_q, rdv_last_d;
    logic              buf_v_q, buf_v_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_last_q, buf_last_d;
    logic [DATA_W-1:0] shf_q, shf_d;
    logic              shf_last_q, shf_last_d;
    logic [31:0]       step_q, step_d;
    logic [2:0]        smp_q, smp_d;

    logic        byte_end;
    logic        start;
    logic        run_n;
    logic        need_load;
    logic        load_next;
    logic [31:0] period_m1;
    logic [2:0]  spb_m1;
    logic [3:0]  n_bits;
    logic [7:0]  gpio_mask;

    // Current byte is on its final cycle: last sample, step counter at terminal count.
    assign byte_end = (state_q == ST_PLAY) && (step_q == 32'd0) && (smp_q == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_FILL;
            ST_FILL: begin
                if (!enable)    state_d = ST_IDLE;
                else if (rdv_q) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (!enable)                    state_d = ST_IDLE;
                else if (byte_end && shf_last_q) state_d = ST_DONE;
            end
            ST_DONE: if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (gsel_q)
            2'd0:    gpio_mask = 8'h01;
            2'd1:    gpio_mask = 8'h03;
            2'd2:    gpio_mask = 8'h0F;
            default: gpio_mask = 8'hFF;
        endcase
        gpio_out = (state_q == ST_PLAY) ? (shf_q & gpio_mask) : 8'h00;
        busy     = (state_q == ST_FILL) || (state_q == ST_PLAY);
        done     = (state_q == ST_DONE);
    end

    assign mem.mem_rd_en = rd_q;
    assign mem.mem_addr  = addr_q;

    always_comb begin
        rep_d        = rep_q;
        end_d        = end_q;
        gsel_d       = gsel_q;
        ts_d         = ts_q;
        rd_d         = 1'b0;
        addr_d       = addr_q;
        rd_last_d    = 1'b0;
        fetch_done_d = fetch_done_q;
        rdv_d        = rdv_q;
        rdv_last_d   = rdv_last_q;
        buf_v_d      = buf_v_q;
        buf_d        = buf_q;
        buf_last_d   = buf_last_q;
        shf_d        = shf_q;
        shf_last_d   = shf_last_q;
        step_d       = step_q;
        smp_d        = smp_q;
        need_load    = 1'b0;
        load_next    = 1'b0;

        start     = (state_q == ST_IDLE) && (state_d == ST_FILL);
        run_n     = (state_d == ST_FILL) || (state_d == ST_PLAY);
        period_m1 = (32'd1 << ts_q) - 32'd1;
        n_bits    = 4'd1 << gsel_q;
        case (gsel_q)
            2'd0:    spb_m1 = 3'd7;
            2'd1:    spb_m1 = 3'd3;
            2'd2:    spb_m1 = 3'd1;
            default: spb_m1 = 3'd0;
        endcase

        if (start) begin
            rep_d  = repeat_enable;
            end_d  = end_address;
            gsel_d = num_gpio_sel;
            ts_d   = timestep_sel;
        end

        if (!run_n) begin
            // Leaving the run (disable or DONE): drop everything, including in-flight data.
            addr_d       = '0;
            fetch_done_d = 1'b0;
            rdv_d        = 1'b0;
            rdv_last_d   = 1'b0;
            buf_v_d      = 1'b0;
            buf_d        = '0;
            buf_last_d   = 1'b0;
            shf_d        = '0;
            shf_last_d   = 1'b0;
            step_d       = '0;
            smp_d        = '0;
        end else begin
            rdv_d      = rd_q;
            rdv_last_d = rd_last_q;
            need_load  = ((state_q == ST_FILL) && rdv_q) || byte_end;

            if (need_load) begin
                if (buf_v_q) begin
                    shf_d      = buf_q;
                    shf_last_d = buf_last_q;
                    buf_v_d    = rdv_q;
                    buf_d      = mem.mem_rdata;
                    buf_last_d = rdv_last_q;
                end else begin
                    // Bypass: the byte arriving this cycle goes straight into the shifter.
                    shf_d      = mem.mem_rdata;
                    shf_last_d = rdv_last_q;
                end
                step_d = period_m1;
                smp_d  = spb_m1;
            end else begin
                if (rdv_q) begin
                    buf_v_d    = 1'b1;
                    buf_d      = mem.mem_rdata;
                    buf_last_d = rdv_last_q;
                end
                if (state_q == ST_PLAY) begin
                    if (step_q == 32'd0) begin
                        step_d = period_m1;
                        smp_d  = smp_q - 3'd1;
                        shf_d  = shf_q >> n_bits;
                    end else begin
                        step_d = step_q - 32'd1;
                    end
                end
            end

            // Issue the next read during the cycle that ends in a shifter load, so the
            // byte lands in time for the following load even at one byte per cycle.
            load_next = ((state_d == ST_FILL) && rdv_d) ||
                        ((state_d == ST_PLAY) && (step_d == 32'd0) && (smp_d == 3'd0));

            if (start) begin
                rd_d         = 1'b1;
                addr_d       = '0;
                rd_last_d    = !repeat_enable && (end_address == '0);
                fetch_done_d = rd_last_d;
            end else if (load_next && !fetch_done_q) begin
                rd_d         = 1'b1;
                addr_d       = (addr_q == end_q) ? '0 : addr_q + ADDR_W'(1);
                rd_last_d    = !rep_q && (addr_d == end_q);
                fetch_done_d = rd_last_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q        <= 1'b0;
            end_q        <= '0;
            gsel_q       <= '0;
            ts_q         <= '0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            rd_last_q    <= 1'b0;
            fetch_done_q <= 1'b0;
            rdv_q        <= 1'b0;
            rdv_last_q   <= 1'b0;
            buf_v_q      <= 1'b0;
            buf_q        <= '0;
            buf_last_q   <= 1'b0;
            shf_q        <= '0;
            shf_last_q   <= 1'b0;
            step_q       <= '0;
            smp_q        <= '0;
        end else begin
            rep_q        <= rep_d;
            end_q        <= end_d;
            gsel_q       <= gsel_d;
            ts_q         <= ts_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            rd_last_q    <= rd_last_d;
            fetch_done_q <= fetch_done_d;
            rdv_q        <= rdv_d;
            rdv_last_q   <= rdv_last_d;
            buf_v_q      <= buf_v_d;
            buf_q        <= buf_d;
            buf_last_q   <= buf_last_d;
            shf_q        <= shf_d;
            shf_last_q   <= shf_last_d;
            step_q       <= step_d;
            smp_q        <= smp_d;
        end
    end
endmodule

// File: tb/tb_pattern_gen_core.sv
module tb_pattern_gen_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rep_en = 1'b0;
    logic [23:0] end_a = '0;
    logic [1:0]  gsel = '0;
    logic [4:0]  ts_sel = '0;
    logic [7:0]  gpio_out;
    logic        busy;
    logic        done;

    pattern_gen_core_if #(.ADDR_W(24), .DATA_W(8)) mem_if ();

    pattern_gen_core #(.ADDR_W(24), .DATA_W(8), .TS_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (en),
        .repeat_enable (rep_en),
        .end_address   (end_a),
        .num_gpio_sel  (gsel),
        .timestep_sel  (ts_sel),
        .mem           (mem_if),
        .gpio_out      (gpio_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_arr [0:255];

    // SRAM: data valid one cycle after the strobe, junk otherwise.
    always @(posedge clk)
        mem_if.mem_rdata <= mem_if.mem_rd_en ? mem_arr[mem_if.mem_addr[7:0]] : 8'($urandom);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: run status and cycles since the edge that first saw enable high.
    bit m_run = 1'b0;
    int m_cyc = 0;
    bit m_rep = 1'b0;
    int m_end = 0;
    int m_gsel = 0;
    int m_ts = 0;

    always @(posedge clk) begin
        if (rst || !en) m_run <= 1'b0;
        else if (!m_run) begin
            m_run  <= 1'b1;
            m_cyc  <= 0;
            m_rep  <= rep_en;
            m_end  <= int'(end_a);
            m_gsel <= int'(gsel);
            m_ts   <= int'(ts_sel);
        end else m_cyc <= m_cyc + 1;
    end

    function automatic void model_outputs(output logic [7:0] g, output logic b, output logic d);
        longint n, spb, per, total, t, s, bidx, k, addr;
        g = 8'h00; b = 1'b0; d = 1'b0;
        if (m_run) begin
            n     = longint'(1) << m_gsel;
            spb   = 8 / n;
            per   = longint'(1) << m_ts;
            total = longint'(m_end + 1) * spb * per;
            if (m_cyc < 2) b = 1'b1;
            else begin
                t = longint'(m_cyc - 2);
                if (!m_rep && t >= total) d = 1'b1;
                else begin
                    b    = 1'b1;
                    s    = t / per;
                    bidx = s / spb;
                    k    = s % spb;
                    addr = bidx % longint'(m_end + 1);
                    g    = 8'((longint'(mem_arr[int'(addr)]) >> (n * k)) & ((longint'(1) << n) - 1));
                end
            end
        end
    endfunction

    int rd_count = 0;
    int exp_addr = 0;

    always @(negedge clk) begin
        logic [7:0] eg;
        logic eb, ed;
        model_outputs(eg, eb, ed);
        check("gpio_out", 32'(gpio_out), 32'(eg));
        check("busy", 32'(busy), 32'(eb));
        check("done", 32'(done), 32'(ed));
        if (!eb) check("rd_quiet", 32'(mem_if.mem_rd_en), 32'd0);
        if (m_run && m_cyc == 0) begin
            check("rd_first", 32'(mem_if.mem_rd_en), 32'd1);
            exp_addr = 0;
            rd_count = 0;
        end
        if (m_run && mem_if.mem_rd_en) begin
            check("rd_addr", 32'(mem_if.mem_addr), 32'(exp_addr));
            exp_addr = (exp_addr == m_end) ? 0 : exp_addr + 1;
            rd_count++;
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_run(input bit rep, input int e, input int g, input int ts);
        rep_en = rep;
        end_a  = 24'(e);
        gsel   = 2'(g);
        ts_sel = 5'(ts);
        en     = 1'b1;
    endtask

    task automatic stop_run();
        en = 1'b0;
        wait_neg(2);
    endtask

    int t2_exp [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    int t4_exp [8] = '{0, 1, 2, 3, 3, 2, 1, 0};

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);

        wait_neg(3);
        check("rst_gpio", 32'(gpio_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd", 32'(mem_if.mem_rd_en), 32'd0);
        check("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        rst = 1'b0;
        wait_neg(2);

        // T1: single byte, 8-bit samples, one cycle each
        mem_arr[0] = 8'hA5;
        start_run(1'b0, 0, 3, 0);
        wait_neg(1);
        check("t1_rd0", 32'(mem_if.mem_rd_en), 32'd1);
        check("t1_addr0", 32'(mem_if.mem_addr), 32'd0);
        check("t1_busy0", 32'(busy), 32'd1);
        wait_neg(2);
        check("t1_gpio", 32'(gpio_out), 32'hA5);
        wait_neg(1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_gpio_off", 32'(gpio_out), 32'd0);
        wait_neg(3);
        @(posedge clk);
        check("t1_reads", 32'(rd_count), 32'd1);
        @(negedge clk);
        stop_run();

        // T2: 1-bit samples, 2 cycles each
        mem_arr[0] = 8'h96;
        start_run(1'b0, 0, 0, 1);
        wait_neg(2);
        for (int i = 0; i < 16; i++) begin
            wait_neg(1);
            check("t2_bit", 32'(gpio_out), 32'(t2_exp[i / 2]));
        end
        wait_neg(1);
        check("t2_done", 32'(done), 32'd1);
        stop_run();

        // T3: repeat over two bytes at one byte per cycle
        mem_arr[0] = 8'h11;
        mem_arr[1] = 8'h22;
        start_run(1'b1, 1, 3, 0);
        wait_neg(2);
        for (int i = 0; i < 8; i++) begin
            wait_neg(1);
            check("t3_gpio", 32'(gpio_out), (i % 2 == 1) ? 32'h22 : 32'h11);
        end
        check("t3_not_done", 32'(done), 32'd0);

        // T5: drop enable for one cycle mid-run, then restart
        en = 1'b0;
        wait_neg(1);
        check("t5_gpio_off", 32'(gpio_out), 32'd0);
        check("t5_busy_off", 32'(busy), 32'd0);
        check("t5_rd_off", 32'(mem_if.mem_rd_en), 32'd0);
        en = 1'b1;
        wait_neg(1);
        check("t5_rd0", 32'(mem_if.mem_rd_en), 32'd1);
        check("t5_addr0", 32'(mem_if.mem_addr), 32'd0);
        wait_neg(2);
        check("t5_gpio0", 32'(gpio_out), 32'h11);
        wait_neg(1);
        check("t5_gpio1", 32'(gpio_out), 32'h22);
        stop_run();

        // T4: 2-bit samples, 4 cycles each, two bytes
        mem_arr[0] = 8'hE4;
        mem_arr[1] = 8'h1B;
        start_run(1'b0, 1, 1, 2);
        wait_neg(2);
        for (int i = 0; i < 32; i++) begin
            wait_neg(1);
            if (i % 4 == 0) check("t4_sample", 32'(gpio_out), 32'(t4_exp[i / 4]));
        end
        wait_neg(1);
        check("t4_done", 32'(done), 32'd1);
        stop_run();

        // T6: timestep change mid-run has no effect; reset mid-run clears all
        mem_arr[0] = 8'h21;
        mem_arr[1] = 8'h43;
        mem_arr[2] = 8'h65;
        mem_arr[3] = 8'h87;
        start_run(1'b1, 3, 2, 1);
        wait_neg(5);
        ts_sel = 5'd0;
        wait_neg(8);
        check("t6_held_period", 32'(gpio_out), 32'd6);
        wait_neg(2);
        rst = 1'b1;
        wait_neg(1);
        check("t6_rst_gpio", 32'(gpio_out), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_rd", 32'(mem_if.mem_rd_en), 32'd0);
        check("t6_rst_addr", 32'(mem_if.mem_addr), 32'd0);
        rst = 1'b0;
        wait_neg(3);
        check("t6_new_s0", 32'(gpio_out), 32'd1);
        wait_neg(1);
        check("t6_new_s1", 32'(gpio_out), 32'd2);
        wait_neg(1);
        check("t6_new_s2", 32'(gpio_out), 32'd3);
        stop_run();

        // Model-only runs: non-repeat multi-byte gapless, 1-bit repeat, 4-bit slow
        for (int i = 0; i < 8; i++) mem_arr[i] = 8'($urandom);
        start_run(1'b0, 4, 3, 0);
        wait_neg(12);
        stop_run();
        start_run(1'b1, 2, 0, 0);
        wait_neg(40);
        stop_run();
        start_run(1'b0, 2, 2, 3);
        wait_neg(56);
        stop_run();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
